// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write-only target receiver.
package i2c_pkg;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h42;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    DATA     = 3'd3,
    DATA_ACK = 3'd4,
    IGNORE   = 3'd5
  } state_e;

  // An addressed write is open from the address ACK until STOP or START.
  function automatic logic is_busy(input state_e s);
    return (s == ADDR_ACK) || (s == DATA) || (s == DATA_ACK);
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer plus history flop for one I2C line, with rise/fall detect.
// Flops reset to 1 so an idle (pulled-up) bus produces no edge on reset release.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q,  hist_d;

  always_comb begin
    sync1_d = line_in;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  always_comb begin
    level = sync2_q;
    rise  = sync2_q & ~hist_q;
    fall  = ~sync2_q & hist_q;
  end

endmodule

// File: rtl/i2c_target_rx.sv
// I2C target receiver: matches a 7-bit write address, ACKs every byte and
// delivers each data byte as a one-cycle strobe. Read requests are NACKed.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bus free or not addressed; waiting for START
// ADDR     | shifting in address + R/W bit
// ADDR_ACK | address matched; drive ACK for one SCL low/high period
// DATA     | shifting in a data byte
// DATA_ACK | data byte taken; drive ACK for one SCL low/high period
// IGNORE   | address mismatch or read; wait for START/STOP, SDA untouched
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       rx_stop,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl_sync (
    .clk     (clk),
    .rst     (rst),
    .line_in (scl_in),
    .level   (scl_lvl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk     (clk),
    .rst     (rst),
    .line_in (sda_in),
    .level   (sda_lvl),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  state_e     state_q, state_d;
  logic [6:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_first_q, rx_first_d;
  logic       rx_stop_q, rx_stop_d;
  logic       first_pend_q, first_pend_d;

  logic       start_det, stop_det;
  logic [7:0] byte_in;
  logic       byte_done;
  logic       addr_match;

  always_comb begin
    start_det  = sda_fall & scl_lvl;
    stop_det   = sda_rise & scl_lvl;
    byte_in    = {shift_q, sda_lvl};
    byte_done  = scl_rise && (bit_cnt_q == 3'd7);
    addr_match = (byte_in[7:1] == DEV_ADDR) && !byte_in[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      sda_oe_q     <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_first_q   <= 1'b0;
      rx_stop_q    <= 1'b0;
      first_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      sda_oe_q     <= sda_oe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_first_q   <= rx_first_d;
      rx_stop_q    <= rx_stop_d;
      first_pend_q <= first_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = IDLE;
    end else if (start_det) begin
      state_d = ADDR;
    end else begin
      case (state_q)
        IDLE:     state_d = IDLE;
        ADDR:     if (byte_done) state_d = addr_match ? ADDR_ACK : IGNORE;
        ADDR_ACK,
        DATA_ACK: if (scl_fall && sda_oe_q) state_d = DATA;
        DATA:     if (byte_done) state_d = DATA_ACK;
        IGNORE:   state_d = IGNORE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Shift register, bit counter and ACK driver; START/STOP abort any partial byte.
  always_comb begin
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    sda_oe_d     = sda_oe_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_first_d   = 1'b0;
    rx_stop_d    = 1'b0;
    first_pend_d = first_pend_q;
    if (stop_det) begin
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      rx_stop_d = is_busy(state_q);
    end else if (start_det) begin
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, DATA: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (byte_done && (state_q == ADDR)) begin
            first_pend_d = addr_match;
          end
          if (byte_done && (state_q == DATA)) begin
            rx_data_d    = byte_in;
            rx_valid_d   = 1'b1;
            rx_first_d   = first_pend_q;
            first_pend_d = 1'b0;
          end
        end
        // First SCL fall after the byte asserts ACK, the next one releases it.
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) sda_oe_d = ~sda_oe_q;
        end
        default: begin
        end
      endcase
    end
  end

  // SDA is released combinationally on reset or a bus condition so the line
  // is never held for an extra cycle after the transfer is abandoned.
  always_comb begin
    sda_oe   = sda_oe_q & ~rst & ~start_det & ~stop_det;
    rx_data  = rx_data_q;
    rx_valid = rx_valid_q;
    rx_first = rx_first_q;
    rx_stop  = rx_stop_q;
    busy     = is_busy(state_q);
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Self-checking bench for i2c_target_rx: table of write transactions plus
// hand-written repeated-START and reset-during-ACK sequences.
`timescale 1ns/1ps
module tb_i2c_target_rx;

  localparam int Q = 8;

  logic       clk;
  logic       rst;
  logic       scl_drv;
  logic       sda_drv;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic       rx_stop;
  logic       busy;

  assign sda_line = sda_drv & ~sda_oe;

  i2c_target_rx #(.DEV_ADDR(7'h42)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_drv),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_first (rx_first),
    .rx_stop  (rx_stop),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       first;
  } exp_t;

  typedef struct {
    logic [7:0] addr_byte;
    int         nbytes;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    bit         exp_ack;
  } vec_t;

  exp_t exp_q[$];
  exp_t exp_e;
  int   errors = 0;
  int   checks = 0;
  int   valid_cnt;
  int   stop_cnt;
  bit   oe_seen;
  bit   busy_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Scoreboard: every rx_valid pops the oldest expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        valid_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rx_valid_unexpected: got data %0h first %0b expected no byte", rx_data, rx_first);
        end else begin
          exp_e = exp_q.pop_front();
          if (rx_data !== exp_e.data || rx_first !== exp_e.first) begin
            errors++;
            $display("FAIL rx_byte: got %0h/first=%0b expected %0h/first=%0b",
                     rx_data, rx_first, exp_e.data, exp_e.first);
          end
        end
      end
      if (rx_stop)  stop_cnt++;
      if (sda_oe)   oe_seen = 1'b1;
      if (busy)     busy_seen = 1'b1;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    valid_cnt = 0;
    stop_cnt  = 0;
    oe_seen   = 1'b0;
    busy_seen = 1'b0;
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; wait_clks(Q);
    scl_drv = 1'b1; wait_clks(Q);
    sda_drv = 1'b0; wait_clks(Q);
    scl_drv = 1'b0; wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; wait_clks(Q);
    scl_drv = 1'b1; wait_clks(Q);
    sda_drv = 1'b1; wait_clks(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_drv = b;    wait_clks(Q);
    scl_drv = 1'b1; wait_clks(2 * Q);
    scl_drv = 1'b0; wait_clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack, output logic oe_after);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_drv = 1'b1; wait_clks(Q);
    scl_drv = 1'b1; wait_clks(Q);
    ack = sda_oe & ~sda_line;
    wait_clks(Q);
    scl_drv = 1'b0; wait_clks(Q);
    oe_after = sda_oe;
  endtask

  function automatic vec_t mk(input logic [7:0] a, input int n, input logic [7:0] d0,
                              input logic [7:0] d1, input logic [7:0] d2, input bit ack);
    vec_t v;
    v.addr_byte = a; v.nbytes = n; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.exp_ack = ack;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    logic       ack, oe_after;
    logic [7:0] d;
    clear_mon();
    i2c_start();
    write_byte(v.addr_byte, ack, oe_after);
    chk("addr_ack", {31'd0, ack}, {31'd0, v.exp_ack});
    chk("addr_ack_release", {31'd0, oe_after}, 32'd0);
    for (int i = 0; i < v.nbytes; i++) begin
      d = (i == 0) ? v.d0 : (i == 1) ? v.d1 : v.d2;
      if (v.exp_ack) exp_q.push_back('{data: d, first: (i == 0)});
      write_byte(d, ack, oe_after);
      chk("data_ack", {31'd0, ack}, {31'd0, v.exp_ack});
      chk("data_ack_release", {31'd0, oe_after}, 32'd0);
    end
    i2c_stop();
    wait_clks(2 * Q);
    chk("rx_stop_count", stop_cnt, v.exp_ack ? 32'd1 : 32'd0);
    chk("rx_valid_count", valid_cnt, v.exp_ack ? v.nbytes : 0);
    chk("busy_seen", {31'd0, busy_seen}, {31'd0, v.exp_ack});
    chk("sda_oe_seen", {31'd0, oe_seen}, {31'd0, v.exp_ack});
    chk("busy_after_stop", {31'd0, busy}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    logic       ack, oe_after;
    logic [7:0] b;
    int         n;

    vecs[0] = mk(8'h84, 1, 8'hA5, 8'h00, 8'h00, 1'b1);  // 0x42 write, one byte
    vecs[1] = mk(8'h86, 1, 8'h11, 8'h00, 8'h00, 1'b0);  // 0x43 write: not us
    vecs[2] = mk(8'h85, 0, 8'h00, 8'h00, 8'h00, 1'b0);  // 0x42 read: NACK
    vecs[3] = mk(8'h84, 3, 8'h01, 8'h02, 8'h03, 1'b1);
    vecs[4] = mk(8'h84, 2, 8'h00, 8'hFF, 8'h00, 1'b1);
    vecs[5] = mk(8'h84, 0, 8'h00, 8'h00, 8'h00, 1'b1);  // address only, then STOP

    rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1;
    clear_mon();
    wait_clks(5);
    chk("reset_sda_oe",   {31'd0, sda_oe},   32'd0);
    chk("reset_rx_data",  {24'd0, rx_data},  32'd0);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_rx_first", {31'd0, rx_first}, 32'd0);
    chk("reset_rx_stop",  {31'd0, rx_stop},  32'd0);
    chk("reset_busy",     {31'd0, busy},     32'd0);
    rst = 1'b0;
    wait_clks(Q);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Partial byte aborted by repeated START, then a full byte.
    clear_mon();
    i2c_start();
    write_byte(8'h84, ack, oe_after);
    chk("rs_addr1_ack", {31'd0, ack}, 32'd1);
    b = 8'hF0;
    for (int i = 7; i >= 4; i--) write_bit(b[i]);
    i2c_start();
    write_byte(8'h84, ack, oe_after);
    chk("rs_addr2_ack", {31'd0, ack}, 32'd1);
    exp_q.push_back('{data: 8'h7E, first: 1'b1});
    write_byte(8'h7E, ack, oe_after);
    chk("rs_data_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    wait_clks(2 * Q);
    chk("rs_valid_count", valid_cnt, 32'd1);
    chk("rs_stop_count", stop_cnt, 32'd1);
    chk("rs_queue_drained", exp_q.size(), 32'd0);

    // Reset asserted while the address ACK is being driven.
    clear_mon();
    i2c_start();
    b = 8'h84;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_drv = 1'b1; wait_clks(Q);
    scl_drv = 1'b1;
    n = 0;
    while (!sda_oe && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ack_before_reset", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_sda_oe",   {31'd0, sda_oe},   32'd0);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_rx_data",  {24'd0, rx_data},  32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_first", {31'd0, rx_first}, 32'd0);
    chk("rst_rx_stop",  {31'd0, rx_stop},  32'd0);
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2 * Q);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    run_vec(mk(8'h84, 1, 8'hC3, 8'h00, 8'h00, 1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
